instr_mem_prog: RTL and testbench
=================================

INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 SHALL have parameter ISIZE, default 18, instruction word width in bits (1..32).
REQ-002 SHALL have parameter ASIZE, default 10, address width; depth = 2**ASIZE words.
REQ-003 SHALL have parameter NOP, default {ISIZE{1'b0}}, word driven on Data_Out while loading.
REQ-004 SHALL have port Clk_In  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst_n_In  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Add_In  input  ASIZE  fetch address.
REQ-007 SHALL have port Fetch_En_In  input  1  fetch enable; low = pipeline stall.
REQ-008 SHALL have port Data_Out  output  ISIZE  registered fetched instruction.
REQ-009 SHALL have port Ld_Start_In  input  1  one-cycle pulse starting a program load at address 0.
REQ-010 SHALL have port Ld_Len_In  input  ASIZE+1  number of words to load; sampled with Ld_Start_In.
REQ-011 SHALL have port Ld_Byte_In  input  8  loader byte stream.
REQ-012 SHALL have port Ld_Valid_In  input  1  Ld_Byte_In valid.
REQ-013 SHALL have port Ld_Ready_Out  output  1  block accepts a byte.
REQ-014 SHALL have port Busy_Out  output  1  high while in LOAD.
REQ-015 SHALL have port Ld_Done_Out  output  1  one-cycle pulse at load completion.
REQ-016 SHALL have port Ld_Err_Out  output  1  sticky load-command error flag.

Function
REQ-017 SHALL hold 2**ASIZE x ISIZE words; single write port (loader) and single read port (fetch).
REQ-018 SHALL implement states IDLE and LOAD; byte transfer occurs on a cycle with Ld_Valid_In=1 and Ld_Ready_Out=1.
REQ-019 Ld_Ready_Out SHALL equal 1 exactly when state is LOAD; Busy_Out SHALL equal Ld_Ready_Out.
REQ-020 IDLE->LOAD SHALL occur on Ld_Start_In=1 with 1 <= Ld_Len_In <= 2**ASIZE; write address and byte counter cleared to 0, remaining count = Ld_Len_In, Ld_Err_Out cleared.
REQ-021 Ld_Start_In with Ld_Len_In=0 in IDLE SHALL stay IDLE, write nothing, and pulse Ld_Done_Out the next cycle.
REQ-022 Ld_Start_In with Ld_Len_In > 2**ASIZE in IDLE SHALL stay IDLE, write nothing, set Ld_Err_Out.
REQ-023 Ld_Start_In during LOAD SHALL be ignored apart from setting Ld_Err_Out; load continues.
REQ-024 Each word SHALL be NB = ceil(ISIZE/8) bytes, MSB byte first; the top NB*8-ISIZE bits of the first byte discarded (ISIZE=18: 3 bytes, top 6 bits of byte 0 dropped).
REQ-025 On transfer of byte NB-1 the assembled word SHALL be written at the write address on that edge; write address +1, remaining -1, byte counter back to 0.
REQ-026 When remaining reaches 0, state SHALL return to IDLE on that same edge and Ld_Done_Out SHALL be 1 for the following cycle only.
REQ-027 In IDLE with Fetch_En_In=1, Data_Out SHALL update to mem[Add_In] on the edge (1-cycle read latency).
REQ-028 In IDLE with Fetch_En_In=0, Data_Out SHALL hold its value.
REQ-029 In LOAD, Data_Out SHALL be set to NOP each edge regardless of Fetch_En_In.
REQ-030 A fetch issued in the first IDLE cycle after a load SHALL return newly written contents.
REQ-031 Words not written by a load SHALL retain prior contents.

Reset
REQ-032 Rst_n_In=0 SHALL asynchronously force state IDLE, Data_Out=NOP, Ld_Ready_Out=0, Busy_Out=0, Ld_Done_Out=0, Ld_Err_Out=0, counters 0.
REQ-033 Reset mid-LOAD SHALL discard the partially assembled word, keep already-written words, and emit no Ld_Done_Out.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 Load Ld_Len_In=2, bytes 03,FF,FF,01,23,45 -> Ld_Done_Out pulses once; fetch addr 0 -> 3FFFF, addr 1 -> 12345, one cycle after Add_In.
REQ-036 Load 1 word with Ld_Valid_In toggled every other cycle -> same word written, Ld_Ready_Out=1 throughout LOAD, Data_Out=NOP throughout.
REQ-037 Ld_Len_In=0 -> Done pulse, no writes; Ld_Len_In=1025 (ASIZE=10) -> Ld_Err_Out=1, stays IDLE; next valid Ld_Start_In clears Ld_Err_Out.
REQ-038 Fetch_En_In=0 for 3 cycles while Add_In changes -> Data_Out unchanged; re-enable -> mem[Add_In] after 1 cycle.
REQ-039 Assert Rst_n_In=0 after 4 of 6 bytes -> all outputs reset immediately; addr 0 holds loaded word, addr 1 holds prior contents.
REQ-040 Full-depth load of 1024 words with data = address -> every address reads back its index; Ld_Start_In pulse mid-load sets Ld_Err_Out without disturbing load.

Source files
------------

// File: rtl/instr_mem_prog.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_prog
//  Brief    : Instruction memory with a single fetch read port and a
//             byte-stream program loader. A load assembles NB bytes (MSB
//             byte first) into each word and writes words from address 0.
//             While loading, the fetch output is forced to NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_prog #(
    parameter int               ISIZE = 18,
    parameter int               ASIZE = 10,
    parameter logic [ISIZE-1:0] NOP   = {ISIZE{1'b0}}
) (
    input  logic             Clk_In,
    input  logic             Rst_n_In,
    input  logic [ASIZE-1:0] Add_In,
    input  logic             Fetch_En_In,
    output logic [ISIZE-1:0] Data_Out,
    input  logic             Ld_Start_In,
    input  logic [ASIZE:0]   Ld_Len_In,
    input  logic [7:0]       Ld_Byte_In,
    input  logic             Ld_Valid_In,
    output logic             Ld_Ready_Out,
    output logic             Busy_Out,
    output logic             Ld_Done_Out,
    output logic             Ld_Err_Out
);

    // Bytes per instruction word (at most 4 for ISIZE <= 32).
    localparam int             c_NUM_BYTES = (ISIZE + 7) / 8;
    localparam logic [1:0]     c_LAST_BYTE = 2'(c_NUM_BYTES - 1);
    localparam logic [ASIZE:0] c_DEPTH     = (ASIZE + 1)'(2 ** ASIZE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             state_q;
    logic [ASIZE-1:0]   wr_addr_q;
    logic [ASIZE:0]     remaining_q;
    logic [1:0]         byte_cnt_q;
    logic [ISIZE-1:0]   asm_q;
    logic [ISIZE-1:0]   data_q;
    logic               done_q;
    logic               err_q;

    logic [ISIZE-1:0]   mem_q [2**ASIZE];

    logic               w_xfer;
    logic               w_last_byte;
    logic               w_wr_en;
    logic               w_len_ok;
    logic [ISIZE-1:0]   asm_d;

    // Byte handshake and word assembly. Shifting through an ISIZE-wide
    // register naturally drops the unused top bits of the first byte.
    always_comb begin
        w_xfer      = (state_q == LOAD) && Ld_Valid_In;
        w_last_byte = (byte_cnt_q == c_LAST_BYTE);
        w_wr_en     = w_xfer && w_last_byte;
        w_len_ok    = (Ld_Len_In != '0) && (Ld_Len_In <= c_DEPTH);
        asm_d       = ISIZE'({asm_q, Ld_Byte_In});
    end

    // Memory write port; contents are deliberately untouched by reset.
    always_ff @(posedge Clk_In) begin
        if (w_wr_en) begin
            mem_q[wr_addr_q] <= asm_d;
        end
    end

    // Loader state machine together with the registered fetch output.
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            data_q      <= NOP;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Fetch_En_In) begin
                        data_q <= mem_q[Add_In];
                    end
                    if (Ld_Start_In) begin
                        if (Ld_Len_In == '0) begin
                            // Empty program: nothing to write, report completion.
                            done_q <= 1'b1;
                        end else if (!w_len_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= LOAD;
                            wr_addr_q   <= '0;
                            byte_cnt_q  <= '0;
                            remaining_q <= Ld_Len_In;
                            err_q       <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    data_q <= NOP;
                    // A restart request mid-load is flagged but not honoured.
                    if (Ld_Start_In) begin
                        err_q <= 1'b1;
                    end
                    if (w_xfer) begin
                        asm_q <= asm_d;
                        if (w_last_byte) begin
                            byte_cnt_q  <= '0;
                            wr_addr_q   <= wr_addr_q + ASIZE'(1);
                            remaining_q <= remaining_q - (ASIZE + 1)'(1);
                            if (remaining_q == (ASIZE + 1)'(1)) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Data_Out     = data_q;
    assign Ld_Ready_Out = (state_q == LOAD);
    assign Busy_Out     = (state_q == LOAD);
    assign Ld_Done_Out  = done_q;
    assign Ld_Err_Out   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_prog
//  Brief    : Directed self-checking bench for instr_mem_prog (ISIZE=18,
//             ASIZE=10, non-zero NOP so NOP forcing is observable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_prog;

    localparam logic [17:0] c_NOP = 18'h2AAAA;

    logic        clk;
    logic        rst_n;
    logic [9:0]  add;
    logic        fetch_en;
    logic [17:0] data_out;
    logic        ld_start;
    logic [10:0] ld_len;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    instr_mem_prog #(
        .ISIZE (18),
        .ASIZE (10),
        .NOP   (c_NOP)
    ) dut (
        .Clk_In       (clk),
        .Rst_n_In     (rst_n),
        .Add_In       (add),
        .Fetch_En_In  (fetch_en),
        .Data_Out     (data_out),
        .Ld_Start_In  (ld_start),
        .Ld_Len_In    (ld_len),
        .Ld_Byte_In   (ld_byte),
        .Ld_Valid_In  (ld_valid),
        .Ld_Ready_Out (ld_ready),
        .Busy_Out     (busy),
        .Ld_Done_Out  (done),
        .Ld_Err_Out   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [10:0] len);
        ld_start = 1'b1;
        ld_len   = len;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic fetch(input logic [9:0] a);
        add      = a;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; add = '0; fetch_en = 1'b0; ld_start = 1'b0;
        ld_len = '0; ld_byte = '0; ld_valid = 1'b0;
        #12;
        total++; if (data_out !== c_NOP) begin bad++; $display("FAIL reset_data got=%h exp=%h", data_out, c_NOP); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ld_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        logic [7:0] bytes [6] = '{8'h03, 8'hFF, 8'hFF, 8'h01, 8'h23, 8'h45};
        start_load(11'd2);
        total++; if (busy !== 1'b1 || ld_ready !== 1'b1) begin bad++; $display("FAIL basic_enter_load got busy=%b ready=%b exp=1/1", busy, ld_ready); end
        for (int k = 0; k < 6; k++) begin
            send_byte(bytes[k]);
            if (k < 5) begin
                total++; if (busy !== 1'b1 || data_out !== c_NOP || done !== 1'b0) begin
                    bad++; $display("FAIL basic_in_load k=%0d got busy=%b data=%h done=%b exp=1/%h/0", k, busy, data_out, done, c_NOP);
                end
            end
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done got done=%b busy=%b exp=1/0", done, busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%b exp=0", done); end
        fetch(10'd0);
        total++; if (data_out !== 18'h3FFFF) begin bad++; $display("FAIL basic_addr0 got=%h exp=3ffff", data_out); end
        fetch(10'd1);
        total++; if (data_out !== 18'h12345) begin bad++; $display("FAIL basic_addr1 got=%h exp=12345", data_out); end
    endtask

    task automatic test_valid_toggle();
        logic [7:0] bytes [3] = '{8'h01, 8'h5A, 8'hA5};
        start_load(11'd1);
        for (int k = 0; k < 5; k++) begin
            ld_valid = (k % 2 == 0);
            ld_byte  = bytes[k / 2];
            tick();
            ld_valid = 1'b0;
            if (k < 4) begin
                total++; if (ld_ready !== 1'b1 || data_out !== c_NOP) begin
                    bad++; $display("FAIL toggle_in_load k=%0d got ready=%b data=%h exp=1/%h", k, ld_ready, data_out, c_NOP);
                end
            end
        end
        total++; if (done !== 1'b1 || ld_ready !== 1'b0) begin bad++; $display("FAIL toggle_done got done=%b ready=%b exp=1/0", done, ld_ready); end
        fetch(10'd0);
        total++; if (data_out !== 18'h15AA5) begin bad++; $display("FAIL toggle_addr0 got=%h exp=15aa5", data_out); end
        fetch(10'd1);
        total++; if (data_out !== 18'h12345) begin bad++; $display("FAIL toggle_addr1_kept got=%h exp=12345", data_out); end
    endtask

    task automatic test_len_zero_and_err();
        start_load(11'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL len0_done got done=%b busy=%b exp=1/0", done, busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL len0_done_once got=%b exp=0", done); end
        fetch(10'd0);
        total++; if (data_out !== 18'h15AA5) begin bad++; $display("FAIL len0_nowrite got=%h exp=15aa5", data_out); end
        start_load(11'd1025);
        total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL overlen_err got err=%b busy=%b exp=1/0", err, busy); end
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL overlen_sticky got=%b exp=1", err); end
        start_load(11'd1);
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_clear got err=%b busy=%b exp=0/1", err, busy); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL err_clear_done got=%b exp=1", done); end
        fetch(10'd0);
        total++; if (data_out !== 18'h00007) begin bad++; $display("FAIL err_clear_addr0 got=%h exp=00007", data_out); end
    endtask

    task automatic test_fetch_stall();
        logic [9:0] addrs [3] = '{10'd0, 10'd2, 10'd0};
        fetch(10'd1);
        total++; if (data_out !== 18'h12345) begin bad++; $display("FAIL stall_pre got=%h exp=12345", data_out); end
        for (int k = 0; k < 3; k++) begin
            add = addrs[k];
            fetch_en = 1'b0;
            tick();
            total++; if (data_out !== 18'h12345) begin bad++; $display("FAIL stall_hold k=%0d got=%h exp=12345", k, data_out); end
        end
        fetch(10'd0);
        total++; if (data_out !== 18'h00007) begin bad++; $display("FAIL stall_resume got=%h exp=00007", data_out); end
    endtask

    task automatic test_reset_mid_load();
        start_load(11'd2);
        send_byte(8'h01);
        ld_start = 1'b1; ld_len = 11'd5;
        send_byte(8'h11);
        ld_start = 1'b0;
        total++; if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midload_start got err=%b busy=%b exp=1/1", err, busy); end
        send_byte(8'h11);
        send_byte(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (data_out !== c_NOP || busy !== 1'b0 || ld_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL async_reset got data=%h busy=%b ready=%b done=%b err=%b exp=%h/0/0/0/0", data_out, busy, ld_ready, done, err, c_NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_no_done got=%b exp=0", done); end
        fetch(10'd0);
        total++; if (data_out !== 18'h11111) begin bad++; $display("FAIL reset_addr0 got=%h exp=11111", data_out); end
        fetch(10'd1);
        total++; if (data_out !== 18'h12345) begin bad++; $display("FAIL reset_addr1 got=%h exp=12345", data_out); end
    endtask

    task automatic test_full_depth();
        start_load(11'd1024);
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            send_byte(8'h00);
            send_byte(iv[15:8]);
            if (i == 500) ld_start = 1'b1;
            send_byte(iv[7:0]);
            ld_start = 1'b0;
            if (i < 1023) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy i=%0d got=%b exp=1", i, busy); end
            end
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_done got done=%b busy=%b exp=1/0", done, busy); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL full_err got=%b exp=1", err); end
        for (int i = 0; i < 1024; i++) begin
            fetch(10'(i));
            total++; if (data_out !== 18'(i)) begin bad++; $display("FAIL full_read addr=%0d got=%h exp=%h", i, data_out, 18'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_valid_toggle();
        test_len_zero_and_err();
        test_fetch_stall();
        test_reset_mid_load();
        test_full_depth();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
